sm4_keyexp_sched: RTL and testbench
===================================

Name: sm4_keyexp_sched

Overview:
- Controller and arbiter in front of the SM4 32-stage key-expansion pipeline.
- Accepts master-key load requests from NUM_REQ requesters and grants them round-robin.
- Holds the granted master key stable for the full pipeline latency and issues a single-cycle valid pulse into the pipeline.
- Captures the 1024-bit round-key vector into one of SLOTS key slots; the cipher datapath reads round keys from these slots.

Parameters:
NUM_REQ, 2, number of key-load requesters (1..4)
SLOTS, 4, number of round-key slots (power of 2, 2..8); SW = log2(SLOTS)
TMO_CYC, 40, watchdog limit in cycles from issue (used only with the optional feature)

Ports:
CLK_i  in  1  clock
RST_i  in  1  synchronous, active-high reset
REQ_VALID_i  in  NUM_REQ  per-requester load request
REQ_READY_o  out  NUM_REQ  per-requester grant/accept; the transfer occurs on VALID&READY
REQ_MK_i  in  128*NUM_REQ  master key; requester r uses bits [128r+127:128r]
REQ_SLOT_i  in  SW*NUM_REQ  target slot for requester r
KE_MK_o  out  128  to key-expansion MK input
KE_MK_VALID_o  out  1  one-cycle issue pulse to key expansion
KE_RK_i  in  1024  round keys from key expansion
KE_RK_READY_i  in  1  round keys valid (one cycle)
SLOT_SEL_i  in  SW  read slot select
RK_o  out  1024  round keys of the selected slot, registered
SLOT_VALID_o  out  SLOTS  per-slot valid bitmap
BUSY_o  out  1  high whenever state is not IDLE
DONE_o  out  1  one-cycle pulse when a slot is written
DONE_ID_o  out  2  requester index of the completed load
ERR_o  out  1  one-cycle watchdog pulse (0 without the optional feature)

Behaviour:
- Reset (synchronous, RST_i=1 at a clock edge):
  - state=IDLE; all outputs 0; SLOT_VALID_o=0; RK_o=0; slot contents cleared.
  - Round-robin pointer points at requester 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any REQ_VALID_i is set, grant the first valid requester at or after the pointer (wrapping).
  - REQ_READY_o is one-hot for that requester, combinational, asserted in IDLE only.
  - On grant, latch MK, slot and requester id; clear SLOT_VALID_o[slot] in the same edge; pointer <= granted+1 (mod NUM_REQ); next state is ISSUE.
- ISSUE:
  - KE_MK_VALID_o=1 for exactly this cycle; KE_MK_o = latched MK.
  - Start the cycle counter at 0; next state is WAIT.
- WAIT:
  - KE_MK_o stays stable; the counter increments.
  - On KE_RK_READY_i=1: write KE_RK_i to the latched slot, set SLOT_VALID_o[slot], and go to IDLE.
  - In the following cycle, DONE_o=1 and DONE_ID_o=latched id.
- KE_MK_o holds its last value in every state; it changes only when the next grant is latched.
- Only one load is in flight at a time. KE_RK_READY_i is ignored in IDLE and ISSUE.
- Latency with a 32-stage pipeline: grant in cycle 0, issue in cycle 1, KE_RK_READY_i in cycle 33, DONE_o and SLOT_VALID in cycle 34.
- A new grant may occur in the same cycle DONE_o is high. Minimum spacing between grants is 34 cycles.
- Read path: RK_o <= slot[SLOT_SEL_i] on every clock, so one cycle of latency.
  - If a slot write and a read of the same slot happen in the same cycle, RK_o shows the old contents; the new contents appear one cycle later.
- Reload of a valid slot: the slot reads as invalid from grant until DONE; its contents are not modified until the capture edge.
- Simultaneous requests: arbitration is round-robin only. A non-granted requester holds VALID and its data stable until READY.
- Reset mid-load: the in-flight load is abandoned and no DONE_o is produced.
  - Integration requires that the key-expansion reset (RST_N_i) is driven from ~RST_i, so its ready chain is cleared with this block.

Optional Feature:
SM4_KEYEXP_SCHED_TMO_EN
- Defined:
  - In WAIT, if the counter reaches TMO_CYC with no KE_RK_READY_i, pulse ERR_o for one cycle, return to IDLE, leave the slot invalid, and produce no DONE_o.
  - A KE_RK_READY_i arriving later is ignored unless the block is back in WAIT for a new load.
- Not defined:
  - WAIT lasts indefinitely; ERR_o is tied to 0; counter compare logic is absent.

Test Plan:
1. Single load: req0 with MK=0123456789ABCDEFFEDCBA9876543210 to slot 1. DONE_o in cycle 34, DONE_ID_o=0, SLOT_VALID_o=0010. With SLOT_SEL_i=1, RK_o[1023:992]=F12186F9 (rk0) and RK_o[31:0]=9124A012 (rk31).
2. Arbitration: both requesters valid continuously from reset. Grants alternate 0,1,0,1; each grant is 34 cycles apart; KE_MK_VALID_o pulses are exactly one cycle wide.
3. Reload of valid slot 1 with MK=0: SLOT_VALID_o[1] drops the cycle after the grant. RK_o keeps the old keys until the capture edge, then shows the new keys one cycle after the write.
4. Reset mid-load: assert RST_i in cycle 15 of WAIT. All outputs are 0 the next cycle; no DONE_o and no KE_RK_READY_i appear afterwards; a fresh load then completes normally in 34 cycles.
5. Spurious KE_RK_READY_i forced high in IDLE: no slot write and SLOT_VALID_o is unchanged.
6. With TMO_EN and a stubbed pipeline that never asserts ready: ERR_o pulses at issue+40, BUSY_o drops, and the target slot stays invalid.

Source files
------------

// File: rtl/sm4_keyexp_sched.sv
// sm4_keyexp_sched: round-robin load controller in front of the SM4 key-expansion
// pipeline. Grants one master-key load at a time, issues a one-cycle valid pulse,
// captures the 32 round keys into a slot and serves a registered slot read port.
// Optional build macro: SM4_KEYEXP_SCHED_TMO_EN adds a WAIT watchdog (ERR_o).
module sm4_keyexp_sched #(
    parameter int NUM_REQ = 2,
    parameter int SLOTS   = 4,
    parameter int TMO_CYC = 40,
    localparam int SW     = $clog2(SLOTS)
) (
    input  logic                    CLK_i,
    input  logic                    RST_i,
    input  logic [NUM_REQ-1:0]      REQ_VALID_i,
    output logic [NUM_REQ-1:0]      REQ_READY_o,
    input  logic [128*NUM_REQ-1:0]  REQ_MK_i,
    input  logic [SW*NUM_REQ-1:0]   REQ_SLOT_i,
    output logic [127:0]            KE_MK_o,
    output logic                    KE_MK_VALID_o,
    input  logic [1023:0]           KE_RK_i,
    input  logic                    KE_RK_READY_i,
    input  logic [SW-1:0]           SLOT_SEL_i,
    output logic [1023:0]           RK_o,
    output logic [SLOTS-1:0]        SLOT_VALID_o,
    output logic                    BUSY_o,
    output logic                    DONE_o,
    output logic [1:0]              DONE_ID_o,
    output logic                    ERR_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    localparam logic [1:0] LAST_REQ = 2'(NUM_REQ - 1);

    // Reject parameter sets the datapath was not sized for.
    if (NUM_REQ < 1 || NUM_REQ > 4 || SLOTS < 2 || SLOTS > 8 ||
        (SLOTS & (SLOTS - 1)) != 0 || TMO_CYC < 2) begin : g_bad_params
        $error("sm4_keyexp_sched: illegal parameter set");
    end

    state_t                state_q, state_d;
    logic [1:0]            ptr_q;
    logic [127:0]          mk_q;
    logic [SW-1:0]         slot_q;
    logic [1:0]            id_q;
    logic [SLOTS-1:0]      valid_q;
    logic [1023:0]         rk_mem_q [SLOTS];
    logic [1023:0]         rk_q;
    logic                  done_q;

    logic                  hi_found, lo_found;
    logic [1:0]            hi_idx, lo_idx;
    logic                  gnt_any;
    logic [1:0]            gnt_idx;
    logic [127:0]          gnt_mk;
    logic [SW-1:0]         gnt_slot;
    logic [NUM_REQ-1:0]    ready;
    logic                  grant, capture, timeout;

    // Round-robin pick: first valid requester at or after the pointer, else the lowest valid one.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (REQ_VALID_i[j] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 2'(j);
            end
            if (REQ_VALID_i[j] && !hi_found && (2'(j) >= ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = 2'(j);
            end
        end
        gnt_any = lo_found;
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    // Select the winner's key and slot, and form the one-hot ready (IDLE only).
    always_comb begin
        gnt_mk   = '0;
        gnt_slot = '0;
        ready    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_idx == 2'(j)) begin
                gnt_mk   = REQ_MK_i[128*j +: 128];
                gnt_slot = REQ_SLOT_i[SW*j +: SW];
            end
            ready[j] = (state_q == ST_IDLE) && gnt_any && (gnt_idx == 2'(j));
        end
    end

    assign grant   = (state_q == ST_IDLE) && gnt_any;
    // Ready from the pipeline only counts while a load is actually waiting for it.
    assign capture = (state_q == ST_WAIT) && KE_RK_READY_i;

`ifdef SM4_KEYEXP_SCHED_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Cycle counter: 0 during ISSUE, so it equals cycles-since-issue while in WAIT.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            cnt_q <= '0;
        end else if (grant) begin
            cnt_q <= '0;
        end else if (state_q != ST_IDLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Give up on the last WAIT cycle so ERR_o rises TMO_CYC cycles after issue.
    assign timeout = (state_q == ST_WAIT) && !KE_RK_READY_i && (cnt_q == CNT_W'(TMO_CYC - 1));

    // One-cycle watchdog pulse.
    always_ff @(posedge CLK_i) begin
        if (RST_i) err_q <= 1'b0;
        else       err_q <= timeout;
    end

    assign ERR_o = err_q;
`else
    assign timeout = 1'b0;
    assign ERR_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
        // the same rule makes a same-edge slot read return the old contents.
        if (RST_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: IDLE -> ISSUE on grant, ISSUE -> WAIT, WAIT -> IDLE on capture or timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (capture || timeout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Load bookkeeping: latch the granted request, advance the pointer, track slot validity.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            ptr_q   <= '0;
            mk_q    <= '0;
            slot_q  <= '0;
            id_q    <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= capture;
            if (grant) begin
                mk_q             <= gnt_mk;
                slot_q           <= gnt_slot;
                id_q             <= gnt_idx;
                valid_q[gnt_slot] <= 1'b0;
                ptr_q            <= (gnt_idx == LAST_REQ) ? 2'd0 : gnt_idx + 2'd1;
            end
            if (capture) begin
                valid_q[slot_q] <= 1'b1;
            end
        end
    end

    // Round-key slot storage and registered read port.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            // NOTE: slot contents are cleared on reset so a stale key can never be read back after a reset.
            for (int k = 0; k < SLOTS; k++) rk_mem_q[k] <= '0;
            rk_q <= '0;
        end else begin
            if (capture) rk_mem_q[slot_q] <= KE_RK_i;
            rk_q <= rk_mem_q[SLOT_SEL_i];
        end
    end

    assign REQ_READY_o   = ready;
    assign KE_MK_o       = mk_q;
    assign KE_MK_VALID_o = (state_q == ST_ISSUE);
    assign RK_o          = rk_q;
    assign SLOT_VALID_o  = valid_q;
    assign BUSY_o        = (state_q != ST_IDLE);
    assign DONE_o        = done_q;
    assign DONE_ID_o     = id_q;

endmodule

// File: tb/tb_sm4_keyexp_sched.sv
// tb_sm4_keyexp_sched: directed bench for sm4_keyexp_sched with a 32-stage stub
// key-expansion pipeline that returns fixed round-key patterns per master key.
module tb_sm4_keyexp_sched;

    localparam int NUM_REQ = 2;
    localparam int SLOTS   = 4;
    localparam int SW      = 2;

    localparam logic [127:0] TV_MK = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] SALT  = 128'hA5A5A5A5_00000000_5A5A5A5A_0F0F0F0F;

    logic                   CLK_i, RST_i;
    logic [NUM_REQ-1:0]     REQ_VALID_i, REQ_READY_o;
    logic [128*NUM_REQ-1:0] REQ_MK_i;
    logic [SW*NUM_REQ-1:0]  REQ_SLOT_i;
    logic [127:0]           KE_MK_o;
    logic                   KE_MK_VALID_o;
    logic [1023:0]          KE_RK_i;
    logic                   KE_RK_READY_i;
    logic [SW-1:0]          SLOT_SEL_i;
    logic [1023:0]          RK_o;
    logic [SLOTS-1:0]       SLOT_VALID_o;
    logic                   BUSY_o, DONE_o, ERR_o;
    logic [1:0]             DONE_ID_o;

    logic force_rdy, stub_dead;
    int   n_pass, n_total;

    sm4_keyexp_sched #(.NUM_REQ(NUM_REQ), .SLOTS(SLOTS), .TMO_CYC(40)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i),
        .REQ_VALID_i(REQ_VALID_i), .REQ_READY_o(REQ_READY_o),
        .REQ_MK_i(REQ_MK_i), .REQ_SLOT_i(REQ_SLOT_i),
        .KE_MK_o(KE_MK_o), .KE_MK_VALID_o(KE_MK_VALID_o),
        .KE_RK_i(KE_RK_i), .KE_RK_READY_i(KE_RK_READY_i),
        .SLOT_SEL_i(SLOT_SEL_i), .RK_o(RK_o), .SLOT_VALID_o(SLOT_VALID_o),
        .BUSY_o(BUSY_o), .DONE_o(DONE_o), .DONE_ID_o(DONE_ID_o), .ERR_o(ERR_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    // Stub pipeline output: the published SM4 rk0/rk31 for the reference key, a salted pattern otherwise.
    function automatic logic [1023:0] rk_of(input logic [127:0] mk);
        if (mk == TV_MK) return {32'hF12186F9, {30{32'h13579BDF}}, 32'h9124A012};
        return {8{mk ^ SALT}};
    endfunction

    // 32-stage stub: valid taken at the issue edge emerges as ready 32 cycles later.
    logic [31:0]  pv;
    logic [127:0] pmk [32];
    always @(posedge CLK_i) begin
        if (RST_i) pv <= '0;
        else       pv <= {pv[30:0], KE_MK_VALID_o & ~stub_dead};
        pmk[0] <= KE_MK_o;
        for (int i = 1; i < 32; i++) pmk[i] <= pmk[i-1];
    end
    assign KE_RK_READY_i = pv[31] | force_rdy;
    assign KE_RK_i       = force_rdy ? {32{32'hBAD0BAD0}} : rk_of(pmk[31]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (int w = 0; w < 32; w++) begin
                if (act[32*w +: 32] !== exp[32*w +: 32]) begin
                    $display("FAIL %s: word %0d got %h, expected %h", name, w, act[32*w +: 32], exp[32*w +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic do_reset();
        RST_i = 1'b1;
        step();
        step();
        RST_i = 1'b0;
    endtask

    // Single load from IDLE; returns one cycle after DONE with SLOT_SEL_i on the loaded slot.
    task automatic do_load(input int r, input logic [127:0] mk, input logic [1:0] slot,
                           input logic [1:0] exp_id, input logic [3:0] exp_valid);
        int         c;
        logic       mk_stable;
        logic [1:0] exp_rdy;
        exp_rdy = 2'b01 << r;
        REQ_MK_i[128*r +: 128] = mk;
        REQ_SLOT_i[2*r +: 2]   = slot;
        REQ_VALID_i            = '0;
        REQ_VALID_i[r]         = 1'b1;
        #1;
        check("grant_ready", REQ_READY_o, exp_rdy);
        step();
        REQ_VALID_i = '0;
        check("issue_pulse", KE_MK_VALID_o, 1'b1);
        check("issue_mk", KE_MK_o, mk);
        check("slot_cleared_on_grant", SLOT_VALID_o[slot], 1'b0);
        check("busy_in_issue", BUSY_o, 1'b1);
        step();
        c = 2;
        check("issue_width", KE_MK_VALID_o, 1'b0);
        mk_stable = 1'b1;
        while (!DONE_o && c < 100) begin
            step();
            c++;
            if (KE_MK_o !== mk) mk_stable = 1'b0;
        end
        check("done_cycle", c, 34);
        check("done_id", DONE_ID_o, exp_id);
        check("slot_valid", SLOT_VALID_o, exp_valid);
        check("mk_hold", mk_stable, 1'b1);
        SLOT_SEL_i = slot;
        step();
        check("done_width", DONE_o, 1'b0);
        check_vec("rk_read", RK_o, rk_of(mk));
    endtask

    typedef struct {
        int           req;
        logic [127:0] mk;
        logic [1:0]   slot;
        logic [1:0]   id;
        logic [31:0]  rk0;
        logic [31:0]  rk31;
        logic [3:0]   valid;
    } load_vec_t;

    load_vec_t vecs [3];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   c, n_g, n_d, n_kv;
        int   gcyc [4];
        int   gid [4];
        int   did [4];
        logic prev_kv, wide, old_ok, inval_ok, quiet;

        n_pass = 0; n_total = 0;
        RST_i = 1'b1; REQ_VALID_i = '0; REQ_MK_i = '0; REQ_SLOT_i = '0; SLOT_SEL_i = '0;
        force_rdy = 1'b0; stub_dead = 1'b0;

        vecs[0] = '{req: 0, mk: TV_MK, slot: 2'd1, id: 2'd0,
                    rk0: 32'hF12186F9, rk31: 32'h9124A012, valid: 4'b0010};
        vecs[1] = '{req: 1, mk: 128'h11112222_33334444_55556666_77778888, slot: 2'd0, id: 2'd1,
                    rk0: 32'hB4B48787, rk31: 32'h78788787, valid: 4'b0011};
        vecs[2] = '{req: 0, mk: 128'hDEADBEEF_00000000_00000000_CAFEF00D, slot: 2'd3, id: 2'd0,
                    rk0: 32'h7B081B4A, rk31: 32'hC5F1FF02, valid: 4'b1011};

        // Reset state.
        do_reset();
        check("rst_busy", BUSY_o, 1'b0);
        check("rst_slot_valid", SLOT_VALID_o, 4'b0000);
        check_vec("rst_rk", RK_o, '0);
        check("rst_mk", KE_MK_o, 128'h0);
        check("rst_mk_valid", KE_MK_VALID_o, 1'b0);
        check("rst_done", DONE_o, 1'b0);
        check("rst_err", ERR_o, 1'b0);
        check("rst_ready", REQ_READY_o, 2'b00);

        // Table-driven single loads.
        for (int i = 0; i < 3; i++) begin
            do_load(vecs[i].req, vecs[i].mk, vecs[i].slot, vecs[i].id, vecs[i].valid);
            check("rk0", RK_o[1023:992], vecs[i].rk0);
            check("rk31", RK_o[31:0], vecs[i].rk31);
        end

        // Reload of valid slot 1 with MK=0: invalid until DONE, old keys until the capture edge.
        SLOT_SEL_i = 2'd1;
        step();
        REQ_MK_i[255:128] = '0;
        REQ_SLOT_i[3:2]   = 2'd1;
        REQ_VALID_i       = 2'b10;
        #1;
        check("reload_ready", REQ_READY_o, 2'b10);
        step();
        REQ_VALID_i = '0;
        c = 1;
        check("reload_invalid", SLOT_VALID_o[1], 1'b0);
        old_ok = 1'b1; inval_ok = 1'b1;
        while (c < 34) begin
            if (RK_o !== rk_of(TV_MK)) old_ok = 1'b0;
            if (SLOT_VALID_o[1]) inval_ok = 1'b0;
            step();
            c++;
        end
        check("reload_old_kept", old_ok, 1'b1);
        check("reload_stays_invalid", inval_ok, 1'b1);
        check_vec("reload_old_at_done", RK_o, rk_of(TV_MK));
        check("reload_done", DONE_o, 1'b1);
        check("reload_valid_again", SLOT_VALID_o, 4'b1011);
        step();
        check_vec("reload_new", RK_o, rk_of(128'h0));

        // Spurious pipeline ready while IDLE must not write anything.
        force_rdy = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (SLOT_VALID_o !== 4'b1011 || DONE_o || BUSY_o) quiet = 1'b0;
        end
        force_rdy = 1'b0;
        check("spurious_quiet", quiet, 1'b1);
        step();
        check_vec("spurious_slot1", RK_o, rk_of(128'h0));
        SLOT_SEL_i = 2'd3;
        step();
        check_vec("spurious_slot3", RK_o, rk_of(vecs[2].mk));

        // Reset in the middle of WAIT.
        REQ_MK_i[127:0] = vecs[2].mk;
        REQ_SLOT_i[1:0] = 2'd2;
        REQ_VALID_i     = 2'b01;
        step();
        REQ_VALID_i = '0;
        c = 1;
        while (c < 16) begin
            step();
            c++;
        end
        check("midload_busy_before", BUSY_o, 1'b1);
        RST_i = 1'b1;
        step();
        check("midrst_busy", BUSY_o, 1'b0);
        check("midrst_slot_valid", SLOT_VALID_o, 4'b0000);
        check_vec("midrst_rk", RK_o, '0);
        check("midrst_mk", KE_MK_o, 128'h0);
        check("midrst_misc", {KE_MK_VALID_o, DONE_o, ERR_o, REQ_READY_o}, 5'b0);
        RST_i = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (DONE_o || KE_RK_READY_i) quiet = 1'b0;
        end
        check("midrst_no_done", quiet, 1'b1);
        do_load(1, vecs[1].mk, 2'd2, 2'd1, 4'b0100);

        // Arbitration: both requesters valid continuously from reset.
        do_reset();
        REQ_MK_i[127:0]   = vecs[2].mk;
        REQ_MK_i[255:128] = vecs[1].mk;
        REQ_SLOT_i        = {2'd3, 2'd2};
        REQ_VALID_i       = 2'b11;
        #1;
        n_g = 0; n_d = 0; n_kv = 0; prev_kv = 1'b0; wide = 1'b0;
        for (int i = 0; i < 4; i++) begin gcyc[i] = -1; gid[i] = -1; did[i] = -1; end
        for (int cy = 0; cy < 170; cy++) begin
            if (REQ_READY_o != 2'b00 && n_g < 4) begin
                gcyc[n_g] = cy;
                gid[n_g]  = REQ_READY_o[1] ? 1 : 0;
                n_g++;
            end
            if (KE_MK_VALID_o) begin
                n_kv++;
                if (prev_kv) wide = 1'b1;
            end
            prev_kv = KE_MK_VALID_o;
            if (DONE_o && n_d < 4) begin
                did[n_d] = int'(DONE_ID_o);
                n_d++;
            end
            step();
            if (n_g == 4) REQ_VALID_i = '0;
        end
        check("arb_grants", n_g, 4);
        check("arb_first_cycle", gcyc[0], 0);
        for (int i = 0; i < 4; i++) check("arb_grant_id", gid[i], i % 2);
        for (int i = 1; i < 4; i++) check("arb_spacing", gcyc[i] - gcyc[i-1], 34);
        check("arb_issue_count", n_kv, 4);
        check("arb_issue_single_cycle", wide, 1'b0);
        check("arb_dones", n_d, 4);
        for (int i = 0; i < 4; i++) check("arb_done_id", did[i], i % 2);
        check("arb_slot_valid", SLOT_VALID_o, 4'b1100);

`ifdef SM4_KEYEXP_SCHED_TMO_EN
        // Watchdog with a pipeline that never answers.
        do_reset();
        stub_dead       = 1'b1;
        REQ_MK_i[127:0] = vecs[1].mk;
        REQ_SLOT_i[1:0] = 2'd0;
        REQ_VALID_i     = 2'b01;
        step();
        REQ_VALID_i = '0;
        c = 1;
        while (!ERR_o && c < 100) begin
            step();
            c++;
        end
        check("tmo_err_cycle", c, 41);
        check("tmo_busy_low", BUSY_o, 1'b0);
        check("tmo_slot_invalid", SLOT_VALID_o, 4'b0000);
        check("tmo_no_done", DONE_o, 1'b0);
        step();
        check("tmo_err_width", ERR_o, 1'b0);
        stub_dead = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
